data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory port. Serves one load/store at a

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a CPU load/store unit (master) and the
// data-memory responder (slave). Both channels use valid/ready handshakes.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves one load/store at a time from word-addressed
// storage it owns, inserting WAIT_CYCLES wait states before each response.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, requests whose
// byte address is not word aligned leave storage untouched and respond with
// resp_err=1, resp_rdata=0. When undefined, resp_err is tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; captures it on the accept edge
// ST_WAIT  | counting wait states; commits the access when cnt reaches 0
// ST_RESP  | response held stable until the core takes it
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  data_mem_if.slave mem
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic            misaligned;

  // Storage is deliberately outside the reset domain; it powers up zeroed.
  logic [31:0]     mem_q [DEPTH_WORDS] = '{default: '0};

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0]      lsb_q, lsb_d;
  logic            unused_addr_bits;

  assign misaligned       = (lsb_q != 2'b00);
  assign unused_addr_bits = ^mem.req_addr[31:AW+2];
`else
  logic            unused_addr_bits;

  // Low address bits are don't-care, so every access is treated as aligned.
  assign misaligned       = 1'b0;
  assign unused_addr_bits = ^{mem.req_addr[31:AW+2], mem.req_addr[1:0]};
`endif

  // Register all control/data state; reset clears the captured request too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      lsb_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_ALIGN_CHECK_EN
      lsb_q   <= lsb_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, commit at zero,
  // then hold the response until the core handshakes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    lsb_d   = lsb_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mem.req_valid) begin
          write_d = mem.req_write;
          idx_d   = mem.req_addr[AW+1:2];
          wdata_d = mem.req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
`ifdef MEM_ALIGN_CHECK_EN
          lsb_d   = mem.req_addr[1:0];
`endif
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (misaligned) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
            err_d = 1'b0;
            if (write_q) begin
              mem_we  = 1'b1;
              rdata_d = wdata_q;
            end else begin
              rdata_d = mem_q[idx_q];
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (mem.resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Storage write port; only the commit step of an aligned store drives it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem.req_ready  = (state_q == ST_IDLE);
  assign mem.resp_valid = (state_q == ST_RESP);
  assign mem.resp_rdata = rdata_q;
  assign mem.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes expected
// responses (data, error flag, accept cycle); a negedge monitor compares
// every cycle the DUT presents a response and pops on handshake.
module tb_data_mem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mem  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compare whenever a response is presented, pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_without_request", sb.size(), 1);
        end else begin
          if (!prev_valid) check("latency", cyc - sb[0].acc, W + 1);
          check("rdata", bus.resp_rdata, sb[0].rdata);
          check("err", bus.resp_err, sb[0].err);
          check("req_ready_busy", bus.req_ready, 0);
          if (bus.resp_ready) void'(sb.pop_front());
        end
      end
      prev_valid = bus.resp_valid && !bus.resp_ready;
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_resp_valid"}, bus.resp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;

    // Reset values held mid-clock
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load, response consumed immediately
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    wait_drain("store_10");
    do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_drain("load_10");

    // Back-pressure: response held for 5 cycles, then released
    bus.resp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_valid("bp");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_req_ready", bus.req_ready, 1);
    check("bp_idle_resp_valid", bus.resp_valid, 0);
    wait_drain("bp");

    // Address wrap modulo DEPTH_WORDS
    do_req(1'b1, 32'h0, 32'h1, 32'h1, 1'b0);
    wait_drain("store_0");
    do_req(1'b0, 32'h400, 32'h0, 32'h1, 1'b0);
    wait_drain("load_400");

    // Top word and ignored upper address bits
    do_req(1'b1, 32'h3FC, 32'hA5A50001, 32'hA5A50001, 1'b0);
    wait_drain("store_3fc");
    do_req(1'b0, 32'hFFFFFFFC, 32'h0, 32'hA5A50001, 1'b0);
    wait_drain("load_fffffffc");

    // Reset while a response is pending drops it
    bus.resp_ready = 1'b0;
    do_req(1'b0, 32'h0, 32'h0, 32'h1, 1'b0);
    wait_valid("rst_resp");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_resp_req_ready", bus.req_ready, 1);
    check("rst_in_resp_valid", bus.resp_valid, 0);
    check("rst_in_resp_rdata", bus.resp_rdata, 0);
    sb.delete();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during WAIT discards the pending store
    do_req(1'b1, 32'h20, 32'h55, 32'h55, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    wait_drain("load_20_after_rst");

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned store is rejected and leaves storage alone
    do_req(1'b1, 32'h22, 32'h77, 32'h0, 1'b1);
    wait_drain("misaligned_store");
    do_req(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    wait_drain("load_20_unchanged");
`else
    // Low address bits ignored: unaligned store lands on its word
    do_req(1'b1, 32'h26, 32'h77, 32'h77, 1'b0);
    wait_drain("unaligned_store");
    do_req(1'b0, 32'h24, 32'h0, 32'h77, 1'b0);
    wait_drain("load_24");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
